uart_rx_core: RTL and testbench

UART_RX_CORE -- requirements
Module: uart_rx_core

---
 rtl/uart_pkg.sv | 41 ++++
 rtl/uart_bit_timer.sv | 36 +++
 rtl/uart_rx_core.sv | 263 ++++++++++++++++++++++++++
 tb/tb_uart_rx_core.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver.
// Holds the receiver state encoding, the parity-mode constants, the timer
// width helper and the parity check helper used by the receive datapath.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } uart_state_e;

  localparam int PAR_NONE = 32'sd0;
  localparam int PAR_ODD  = 32'sd1;
  localparam int PAR_EVEN = 32'sd2;

  // Bits needed by the bit timer to hold CLKS_PER_BIT-1.
  function automatic int cnt_width(input int clks_per_bit);
    if (clks_per_bit <= 32'sd2) begin
      return 32'sd1;
    end else begin
      return $clog2(clks_per_bit);
    end
  endfunction

  // Parity mismatch for a payload (zero-extended to 9 bits) and its parity bit.
  function automatic logic parity_error(input logic [8:0] payload,
                                        input logic       par_bit,
                                        input int         mode);
    logic x;
    x = (^payload) ^ par_bit;
    case (mode)
      PAR_ODD:  return ~x;
      PAR_EVEN: return x;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Down-counting bit timer for the UART receiver.
// Ports:
//   clk        - clock
//   rst        - synchronous active-high reset, clears the count
//   load       - reload strobe
//   load_value - value loaded on the load strobe
//   zero       - high while the count is zero
// The count stops at zero until the next load.
module uart_bit_timer #(
  parameter int WIDTH = 32'sd4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             zero
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1'b1);

  logic [WIDTH-1:0] count_r;

  // Count register: reload on strobe, otherwise count down to zero and hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= '0;
    end else if (load) begin
      count_r <= load_value;
    end else if (count_r != '0) begin
      count_r <= count_r - ONE;
    end
  end

  assign zero = (count_r == '0);

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver core.
// Ports:
//   clk        - single clock
//   rst        - synchronous active-high reset
//   rx         - asynchronous serial input, idle high
//   data       - received payload (LSB first on the wire)
//   valid      - data and error flags held until accepted
//   ready      - consumer accepts data when high with valid
//   parity_err - parity mismatch, qualified by valid
//   frame_err  - a stop bit was sampled low, qualified by valid
//   overrun    - one-cycle pulse when a completed frame is dropped
//   busy       - receiver is in any state other than IDLE
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 32'sd625,
  parameter int DATA_BITS    = 32'sd8,
  parameter int PARITY       = 32'sd0,
  parameter int STOP_BITS    = 32'sd1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  if (CLKS_PER_BIT < 32'sd4) begin : g_bad_clks_per_bit
    $error("uart_rx_core: CLKS_PER_BIT must be 4 or more");
  end
  if ((DATA_BITS < 32'sd5) || (DATA_BITS > 32'sd9)) begin : g_bad_data_bits
    $error("uart_rx_core: DATA_BITS must be in 5..9");
  end
  if ((PARITY != PAR_NONE) && (PARITY != PAR_ODD) && (PARITY != PAR_EVEN)) begin : g_bad_parity
    $error("uart_rx_core: PARITY must be 0, 1 or 2");
  end
  if ((STOP_BITS != 32'sd1) && (STOP_BITS != 32'sd2)) begin : g_bad_stop_bits
    $error("uart_rx_core: STOP_BITS must be 1 or 2");
  end

  localparam int CW = cnt_width(CLKS_PER_BIT);
  // First sample lands mid start bit; later samples one full bit apart.
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 32'sd2 - 32'sd1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 32'sd1);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 32'sd1);
  localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 32'sd1);

  logic                 rx_meta_r;
  logic                 rxs_r;
  uart_state_e          state_r;
  uart_state_e          state_next_s;
  logic [3:0]           bit_idx_r;
  logic [DATA_BITS-1:0] shift_r;
  logic                 par_err_r;
  logic                 frm_err_r;
  logic                 all_zero_r;
  logic                 timer_load_s;
  logic [CW-1:0]        timer_value_s;
  logic                 timer_zero_s;
  logic                 complete_s;
  logic                 frm_err_fin_s;
  logic                 all_zero_fin_s;
  logic [DATA_BITS-1:0] data_r;
  logic                 valid_r;
  logic                 parity_err_r;
  logic                 frame_err_r;
  logic                 overrun_r;
  logic                 busy_r;

  uart_bit_timer #(.WIDTH(CW)) u_bit_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (timer_load_s),
    .load_value (timer_value_s),
    .zero       (timer_zero_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic, timer reload control and frame-completion decode.
  always_comb begin
    state_next_s   = state_r;
    timer_load_s   = 1'b0;
    timer_value_s  = FULL_LOAD;
    complete_s     = 1'b0;
    // Error/break status including the stop sample currently being taken.
    frm_err_fin_s  = frm_err_r | ~rxs_r;
    all_zero_fin_s = all_zero_r & ~rxs_r;
    case (state_r)
      ST_IDLE: begin
        if (!rxs_r) begin
          state_next_s  = ST_START;
          timer_load_s  = 1'b1;
          timer_value_s = HALF_LOAD;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (timer_zero_s) begin
          timer_load_s = 1'b1;
          if (rxs_r) begin
            state_next_s = ST_IDLE;
          end else begin
            state_next_s = ST_DATA;
          end
        end else begin
          state_next_s = ST_START;
        end
      end
      ST_DATA: begin
        if (timer_zero_s) begin
          timer_load_s = 1'b1;
          if (bit_idx_r == LAST_DATA) begin
            if (PARITY != PAR_NONE) begin
              state_next_s = ST_PARITY;
            end else begin
              state_next_s = ST_STOP;
            end
          end else begin
            state_next_s = ST_DATA;
          end
        end else begin
          state_next_s = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (timer_zero_s) begin
          timer_load_s = 1'b1;
          state_next_s = ST_STOP;
        end else begin
          state_next_s = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (timer_zero_s) begin
          timer_load_s = 1'b1;
          if (bit_idx_r == LAST_STOP) begin
            complete_s = 1'b1;
            // An all-zero errored frame is a line break: wait for idle.
            if (frm_err_fin_s && all_zero_fin_s) begin
              state_next_s = ST_BREAK;
            end else begin
              state_next_s = ST_IDLE;
            end
          end else begin
            state_next_s = ST_STOP;
          end
        end else begin
          state_next_s = ST_STOP;
        end
      end
      ST_BREAK: begin
        if (rxs_r) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_BREAK;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Input synchronizer, bit index and per-frame receive accumulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_r  <= 1'b1;
      rxs_r      <= 1'b1;
      bit_idx_r  <= 4'd0;
      shift_r    <= '0;
      par_err_r  <= 1'b0;
      frm_err_r  <= 1'b0;
      all_zero_r <= 1'b0;
    end else begin
      rx_meta_r <= rx;
      rxs_r     <= rx_meta_r;
      // Bit index restarts on every state change and counts samples within DATA/STOP.
      if (state_next_s != state_r) begin
        bit_idx_r <= 4'd0;
      end else if (timer_zero_s && ((state_r == ST_DATA) || (state_r == ST_STOP))) begin
        bit_idx_r <= bit_idx_r + 4'd1;
      end
      case (state_r)
        ST_START: begin
          if (timer_zero_s) begin
            par_err_r  <= 1'b0;
            frm_err_r  <= 1'b0;
            all_zero_r <= 1'b1;
          end
        end
        ST_DATA: begin
          if (timer_zero_s) begin
            shift_r    <= {rxs_r, shift_r[DATA_BITS-1:1]};
            all_zero_r <= all_zero_r & ~rxs_r;
          end
        end
        ST_PARITY: begin
          if (timer_zero_s) begin
            par_err_r <= parity_error(9'(shift_r), rxs_r, PARITY);
          end
        end
        ST_STOP: begin
          if (timer_zero_s) begin
            frm_err_r  <= frm_err_fin_s;
            all_zero_r <= all_zero_fin_s;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Output holding register with valid/ready handshake and overrun detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_r       <= '0;
      valid_r      <= 1'b0;
      parity_err_r <= 1'b0;
      frame_err_r  <= 1'b0;
      overrun_r    <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      overrun_r <= 1'b0;
      busy_r    <= (state_next_s != ST_IDLE);
      if (complete_s) begin
        // Held word is free if empty or being accepted this very cycle.
        if (!valid_r || ready) begin
          data_r       <= shift_r;
          parity_err_r <= par_err_r;
          frame_err_r  <= frm_err_fin_s;
          valid_r      <= 1'b1;
        end else begin
          overrun_r <= 1'b1;
        end
      end else if (valid_r && ready) begin
        valid_r <= 1'b0;
      end
    end
  end

  assign data       = data_r;
  assign valid      = valid_r;
  assign parity_err = parity_err_r;
  assign frame_err  = frame_err_r;
  assign overrun    = overrun_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed self-checking bench for uart_rx_core at 16 clocks per bit:
// an 8N1 instance (dut) and an 8E1 instance (dut_p).
module tb_uart_rx_core;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       ready = 1'b1;
  logic [7:0] data;
  logic       valid, parity_err, frame_err, overrun, busy;

  logic       rx_p = 1'b1;
  logic       ready_p = 1'b1;
  logic [7:0] data_p;
  logic       valid_p, parity_err_p, frame_err_p, overrun_p, busy_p;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  int         cyc = 0;
  int         start_cyc = 0;
  int         xfers = 0, valid_hi = 0, ovr_cnt = 0, rise_cyc = 0;
  logic       valid_q = 1'b0;
  logic [7:0] last_data = 8'h00;
  logic       last_perr = 1'b0, last_ferr = 1'b0;
  int         xfers_p = 0;
  logic [7:0] last_data_p = 8'h00;
  logic       last_perr_p = 1'b0;

  uart_rx_core #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut (
    .clk(clk), .rst(rst), .rx(rx), .data(data), .valid(valid), .ready(ready),
    .parity_err(parity_err), .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );

  uart_rx_core #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_p (
    .clk(clk), .rst(rst), .rx(rx_p), .data(data_p), .valid(valid_p), .ready(ready_p),
    .parity_err(parity_err_p), .frame_err(frame_err_p), .overrun(overrun_p), .busy(busy_p)
  );

  always #5 clk = ~clk;

  // Transfer monitor: sees pre-edge values, so valid&&ready here is a real handshake.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    valid_q <= valid;
    if (valid && !valid_q) rise_cyc <= cyc;
    if (valid) valid_hi <= valid_hi + 1;
    if (overrun) ovr_cnt <= ovr_cnt + 1;
    if (valid && ready) begin
      xfers <= xfers + 1;
      last_data <= data;
      last_perr <= parity_err;
      last_ferr <= frame_err;
    end
    if (valid_p && ready_p) begin
      xfers_p <= xfers_p + 1;
      last_data_p <= data_p;
      last_perr_p <= parity_err_p;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive n bits (bit 0 first) on line 0 (rx) or line 1 (rx_p), one bit per CPB clocks.
  task automatic send(input logic [31:0] bits, input int n, input int line);
    if (line == 0) start_cyc = cyc;
    for (int i = 0; i < n; i++) begin
      if (line == 0) rx = bits[i];
      else rx_p = bits[i];
      repeat (CPB) @(negedge clk);
    end
  endtask

  function automatic logic [31:0] f8n1(input logic [7:0] b);
    return {22'd0, 1'b1, b, 1'b0};
  endfunction

  function automatic logic [31:0] f8e1(input logic [7:0] b, input logic p);
    return {21'd0, 1'b1, p, b, 1'b0};
  endfunction

  int x0, v0, o0;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_data", 32'(data), 32'h00);
    check("rst_perr", 32'(parity_err), 32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // 8N1 0xA5 with ready=1
    x0 = xfers; v0 = valid_hi; o0 = ovr_cnt;
    send(f8n1(8'hA5), 10, 0);
    repeat (20) @(negedge clk);
    check("a5_xfers", 32'(xfers - x0), 32'd1);
    check("a5_data", 32'(last_data), 32'hA5);
    check("a5_perr", 32'(last_perr), 32'd0);
    check("a5_ferr", 32'(last_ferr), 32'd0);
    check("a5_valid_cycles", 32'(valid_hi - v0), 32'd1);
    check("a5_latency", 32'(rise_cyc - start_cyc), 32'd155);
    check("a5_overrun", 32'(ovr_cnt - o0), 32'd0);

    // Even parity: 0x03 has even ones, so parity bit 1 is an error
    send(f8e1(8'h03, 1'b1), 11, 1);
    repeat (20) @(negedge clk);
    check("par1_data", 32'(last_data_p), 32'h03);
    check("par1_perr", 32'(last_perr_p), 32'd1);
    send(f8e1(8'h03, 1'b0), 11, 1);
    repeat (20) @(negedge clk);
    check("par0_xfers", 32'(xfers_p), 32'd2);
    check("par0_perr", 32'(last_perr_p), 32'd0);

    // 5-cycle glitch: false start
    x0 = xfers;
    rx = 1'b0;
    repeat (5) @(negedge clk);
    check("glitch_busy_high", 32'(busy), 32'd1);
    rx = 1'b1;
    for (int i = 0; i < 10 && busy; i++) @(negedge clk);
    check("glitch_busy_low", 32'(busy), 32'd0);
    repeat (30) @(negedge clk);
    check("glitch_no_valid", 32'(xfers - x0), 32'd0);

    // Overrun: two frames while ready=0
    ready = 1'b0;
    x0 = xfers; o0 = ovr_cnt;
    send(f8n1(8'h11), 10, 0);
    send(f8n1(8'h22), 10, 0);
    repeat (20) @(negedge clk);
    check("ovr_valid", 32'(valid), 32'd1);
    check("ovr_data", 32'(data), 32'h11);
    check("ovr_pulses", 32'(ovr_cnt - o0), 32'd1);
    check("ovr_no_xfer", 32'(xfers - x0), 32'd0);
    ready = 1'b1;
    @(negedge clk);
    check("ovr_valid_drop", 32'(valid), 32'd0);
    repeat (20) @(negedge clk);
    check("ovr_one_xfer", 32'(xfers - x0), 32'd1);
    check("ovr_xfer_data", 32'(last_data), 32'h11);

    // Break: rx low for 20 bit times
    x0 = xfers;
    rx = 1'b0;
    repeat (20 * CPB) @(negedge clk);
    check("brk_busy", 32'(busy), 32'd1);
    check("brk_xfers", 32'(xfers - x0), 32'd1);
    check("brk_data", 32'(last_data), 32'h00);
    check("brk_ferr", 32'(last_ferr), 32'd1);
    rx = 1'b1;
    repeat (10) @(negedge clk);
    check("brk_busy_low", 32'(busy), 32'd0);
    send(f8n1(8'h5A), 10, 0);
    repeat (20) @(negedge clk);
    check("post_brk_data", 32'(last_data), 32'h5A);
    check("post_brk_ferr", 32'(last_ferr), 32'd0);

    // Reset mid-DATA of 0xFF, then 0x3C
    x0 = xfers;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_valid", 32'(valid), 32'd0);
    repeat (8 * CPB) @(negedge clk);
    check("mid_rst_no_xfer", 32'(xfers - x0), 32'd0);
    send(f8n1(8'h3C), 10, 0);
    repeat (20) @(negedge clk);
    check("mid_rst_xfers", 32'(xfers - x0), 32'd1);
    check("mid_rst_data", 32'(last_data), 32'h3C);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
